// File: rtl/apb4_slave_mem.sv
// APB4 completer backed by a word-addressed memory.
// Byte strobes, fixed wait states and error response on bad addresses.
module apb4_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int IW = $clog2(DEPTH);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);
    localparam logic [ADDR_WIDTH:0] ADDR_LIM = (ADDR_WIDTH + 1)'(DEPTH * 4);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  mem_we;
    logic                  ready;
    logic [IW-1:0]         addr_idx;
    logic                  addr_err;
    logic                  unused_prot;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign addr_idx = PADDR[IW+1:2];
    assign addr_err = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= ADDR_LIM);
    assign unused_prot = ^PPROT;

    assign ready   = (state_q == ACCESS) && (cnt_q == WAIT_LIM);
    assign PREADY  = ready;
    assign PSLVERR = ready & err_q;
    assign PRDATA  = rdata_q;

    // Next-state logic: capture on setup, count waits, complete or abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    idx_d   = addr_idx;
                    wr_d    = PWRITE;
                    err_d   = addr_err;
                    if (!PWRITE) begin
                        rdata_d = addr_err ? '0 : mem[addr_idx];
                    end
                end
            end
            ACCESS: begin
                if (!(PSEL && PENABLE)) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = IDLE;
                    mem_we  = wr_q && !err_q;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, asynchronously cleared.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage: byte-lane writes at the completion edge, never reset.
    always_ff @(posedge PCLK) begin
        for (int i = 0; i < SW; i++) begin
            if (mem_we && PSTRB[i]) begin
                mem[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Scoreboard bench for apb4_slave_mem.
// Three instances cover 0, 3 and 2 wait states on a shared bus.
module tb_apb4_slave_mem;

    typedef struct packed {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int n_tests;
    int n_fail;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    apb4_slave_mem #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata[0]), .PREADY(pready[0]),
        .PSLVERR(pslverr[0])
    );

    apb4_slave_mem #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata[1]), .PREADY(pready[1]),
        .PSLVERR(pslverr[1])
    );

    apb4_slave_mem #(.WAIT_CYCLES(2)) u_w2 (
        .PCLK(clk), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PPROT(pprot), .PRDATA(prdata[2]), .PREADY(pready[2]),
        .PSLVERR(pslverr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Monitor: every PREADY pops the next expected response for that slave.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (pready[k]) begin
                exp_t e;
                bit   got;
                got = 1'b0;
                e   = '0;
                case (k)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                endcase
                chk($sformatf("unexpected_pready[%0d]", k), 32'(got), 32'd1);
                if (got) begin
                    chk($sformatf("pslverr[%0d]", k), 32'(pslverr[k]), 32'(e.err));
                    if (e.rd) begin
                        chk($sformatf("prdata[%0d]", k), prdata[k], e.data);
                    end
                end
            end
        end
    end

    // One transfer; ends in the completion cycle so the next may follow directly.
    task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input logic [31:0] exp_rd, input bit exp_err,
                        input int waits);
        int n;
        exp_t e;
        e.rd   = !wr;
        e.data = exp_rd;
        e.err  = exp_err;
        push(d, e);
        @(posedge clk); #1;
        psel    = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = a;
        pwdata  = wd;
        pstrb   = st;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pready[d]) break;
            n++;
            if (n > 40) begin
                $display("FAIL timeout: no PREADY on slave %0d addr %h", d, a);
                n_fail++;
                break;
            end
        end
        chk($sformatf("latency[%0d]@%h", d, a), 32'(n), 32'(waits));
    endtask

    task automatic idle(input int cyc);
        @(posedge clk); #1;
        psel    = '0;
        penable = 1'b0;
        repeat (cyc) @(posedge clk);
    endtask

    initial begin
        int hits;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        psel    = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_pready[%0d]", k), 32'(pready[k]), 32'd0);
            chk($sformatf("rst_pslverr[%0d]", k), 32'(pslverr[k]), 32'd0);
            chk($sformatf("rst_prdata[%0d]", k), prdata[k], 32'd0);
        end
        rst_n = 1'b1;
        idle(1);

        // PSEL+PENABLE in IDLE without setup is ignored
        @(posedge clk); #1;
        psel[0] = 1'b1;
        penable = 1'b1;
        @(negedge clk);
        chk("no_setup_pready", 32'(pready[0]), 32'd0);
        idle(1);

        // Zero-wait write then read
        xfer(0, 1, 32'h4, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0);
        xfer(0, 0, 32'h4, 32'h0, 4'h0, 32'hDEADBEEF, 0, 0);
        idle(1);

        // Byte strobes
        xfer(0, 1, 32'h8, 32'h11223344, 4'hF, 32'h0, 0, 0);
        xfer(0, 1, 32'h8, 32'hAABBCCDD, 4'h5, 32'h0, 0, 0);
        xfer(0, 0, 32'h8, 32'h0, 4'hF, 32'h11BB33DD, 0, 0);
        idle(1);

        // Errors leave memory untouched
        xfer(0, 1, 32'h0, 32'h55AA55AA, 4'hF, 32'h0, 0, 0);
        xfer(0, 1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);
        xfer(0, 1, 32'h2, 32'hFFFFFFFF, 4'hF, 32'h0, 1, 0);
        xfer(0, 0, 32'h0, 32'h0, 4'h0, 32'h55AA55AA, 0, 0);
        xfer(0, 0, 32'h1000, 32'h0, 4'h0, 32'h0, 1, 0);
        idle(1);

        // Back-to-back burst
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1, 32'h40 + 32'(i * 4), 32'hA5000000 + 32'(i) * 32'h01010101,
                 4'hF, 32'h0, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 0, 32'h40 + 32'(i * 4), 32'h0, 4'hF,
                 32'hA5000000 + 32'(i) * 32'h01010101, 0, 0);
        end
        idle(1);

        // Three wait states on the last word
        xfer(1, 1, 32'hFFC, 32'h600DF00D, 4'hF, 32'h0, 0, 3);
        xfer(1, 0, 32'hFFC, 32'h0, 4'h0, 32'h600DF00D, 0, 3);
        idle(1);

        // Abort by dropping PENABLE with two wait states
        xfer(2, 1, 32'h20, 32'h12345678, 4'hF, 32'h0, 0, 2);
        idle(1);
        hits = 0;
        @(posedge clk); #1;
        psel[2] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h20;
        pwdata  = 32'hFFFFFFFF;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        if (pready[2]) hits++;
        @(posedge clk); #1;
        penable = 1'b0;
        @(negedge clk);
        if (pready[2]) hits++;
        @(posedge clk); #1;
        psel = '0;
        repeat (4) begin
            @(negedge clk);
            if (pready[2]) hits++;
        end
        chk("abort_pready", 32'(hits), 32'd0);
        xfer(2, 0, 32'h20, 32'h0, 4'h0, 32'h12345678, 0, 2);
        idle(1);

        // Reset in the middle of a write
        xfer(0, 1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 0, 0);
        idle(1);
        @(posedge clk); #1;
        psel[0] = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'h0BADBEEF;
        pstrb   = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pready", 32'(pready[0]), 32'd0);
        chk("midrst_pslverr", 32'(pslverr[0]), 32'd0);
        chk("midrst_prdata", prdata[0], 32'd0);
        psel    = '0;
        penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        xfer(0, 0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 0, 0);
        idle(3);

        chk("leftover_q0", 32'(q0.size()), 32'd0);
        chk("leftover_q1", 32'(q1.size()), 32'd0);
        chk("leftover_q2", 32'(q2.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb4_slave_mem.md
# apb4_slave_mem

APB4 completer holding a 1024 x 32-bit word-addressed memory with byte strobes, programmable wait states and error response. It is the DUT driven by the APB4 slave VIP environment: the VIP's driver issues transfers into this block, and its monitor and scoreboard check the responses.

## Interface
Parameters:
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, PWDATA/PRDATA width; PSTRB width is DATA_WIDTH/8
- DEPTH, 1024, number of DATA_WIDTH words
- WAIT_CYCLES, 0, extra access cycles before PREADY (0..15)

Ports:
- PCLK  in  1  clock; all state updates on the rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  completer select
- PENABLE  in  1  access phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_WIDTH  byte address
- PWDATA  in  DATA_WIDTH  write data
- PSTRB  in  DATA_WIDTH/8  write byte-lane enables
- PPROT  in  3  accepted, ignored
- PRDATA  out  DATA_WIDTH  read data
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response, valid only when PREADY=1

## Operation
- Address decode:
  - word index = PADDR[log2(DEPTH)+1:2]
  - error if PADDR[1:0] != 0 or PADDR >= DEPTH*4
- FSM, two states plus a 4-bit wait counter `cnt`:
  - IDLE: at the edge where PSEL=1 and PENABLE=0 (setup cycle), go to ACCESS, clear `cnt`, and latch index, PWRITE and the error flag.
  - IDLE, same edge, read: PRDATA <= mem[index] if no error, else 0.
  - ACCESS: PREADY = (cnt == WAIT_CYCLES), derived combinationally from registered state.
  - ACCESS, edge with PSEL=1, PENABLE=1, PREADY=0: cnt <= cnt+1.
  - ACCESS, edge with PSEL=1, PENABLE=1, PREADY=1: transfer completes, go to IDLE.
  - ACCESS, edge with PSEL=0 or PENABLE=0: abort. Go to IDLE; no write, no error.
- Write completion without error: for each lane i with PSTRB[i]=1, mem[index][8i+7:8i] <= PWDATA[8i+7:8i]. Lanes with PSTRB[i]=0 are unchanged.
- Write completion with error: memory unchanged.
- PSTRB is ignored on reads.
- PSLVERR = PREADY & latched error flag.
- PRDATA holds its last value outside read transfers.
- Memory array is not reset; contents survive PRESETn.

## Timing
- Reset (PRESETn=0, asynchronous): state IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0. Applies immediately, including mid-transfer; the interrupted write is not performed.
- Setup cycle at T. With WAIT_CYCLES=N, PREADY=1 during cycle T+1+N; the transfer occupies N+2 cycles.
- Memory write takes effect at the completion edge. A read in the immediately following transfer returns the new data.
- Back-to-back: a new setup cycle may directly follow the completion cycle, with no idle gap.
- PSEL=1 with PENABLE=1 while in IDLE (no setup seen): ignored, PREADY stays 0.
- PREADY and PSLVERR are 0 in IDLE and in every non-final ACCESS cycle.
- PADDR, PWRITE and PSTRB changing during ACCESS is a protocol violation. Latched values are used, except PSTRB and PWDATA, which are sampled at the completion edge.

## Test plan
- Reset mid-transfer: assert PRESETn=0 during the ACCESS of a write to 0x10 -> PREADY/PSLVERR/PRDATA=0 immediately, and a later read of 0x10 shows the old value.
- Zero-wait write then read: write 0xDEADBEEF to 0x0004 with PSTRB=0xF, then read 0x0004 -> each PREADY occurs 1 cycle after setup, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0x11223344 to 0x0008 with PSTRB=0xF, then 0xAABBCCDD with PSTRB=0x5, then read -> 0x11BB33DD.
- Wait states: with WAIT_CYCLES=3, read 0x0FFC (last word) -> PREADY asserted exactly 4 cycles after setup, and only in that cycle.
- Errors: write to 0x1000 (out of range) and to 0x0002 (misaligned) -> PSLVERR=1 with PREADY; memory unchanged; an out-of-range read returns PRDATA=0.
- Back-to-back and abort:
  - 8 consecutive writes then reads, no idle cycles -> all data match.
  - Drop PENABLE during a WAIT_CYCLES=2 write -> no PREADY and no memory change.
